// File: rtl/apb_ratio_delayer_pkg.sv
// apb_delayer_pkg: shared FSM state type and saturating helpers for apb_ratio_delayer.
// Revision 1.0
`default_nettype none

package apb_delayer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // All-ones value of a w-bit counter, held in 64 bits so any CNT_W up to 64 fits.
  function automatic logic [63:0] cnt_max(input int w);
    return {64{1'b1}} >> (64 - w);
  endfunction

  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] max);
    if (a >= max) return max;
    if (b > max - a) return max;
    return a + b;
  endfunction

  function automatic logic [63:0] sat_sub(input logic [63:0] a, input logic [63:0] b);
    return (a > b) ? a - b : 64'd0;
  endfunction

  function automatic bit params_legal(input int rd_num, input int wr_num, input int den,
                                      input int cnt_w);
    return (den >= 1) && (rd_num >= den) && (wr_num >= den) && (cnt_w >= 1) && (cnt_w <= 64);
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_ratio_delayer_if.sv
// apb_ratio_delayer_if: one APB link; slave modport faces the master, master modport faces the device.
// Revision 1.0
`default_nettype none

interface apb_ratio_delayer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   paddr;
  logic                psel;
  logic                penable;
  logic [2:0]          pprot;
  logic                pwrite;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W/8-1:0] pstrb;
  logic                pready;
  logic [DATA_W-1:0]   prdata;
  logic                pslverr;

  modport master (
    output paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

`default_nettype wire

// File: rtl/apb_ratio_delayer_acc.sv
// delay_acc: saturating stretch accumulator (clear > load > add > sub-DEN) with acc<=DEN flag.
// Revision 1.0
`default_nettype none

module delay_acc
  import apb_delayer_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int DEN   = 100
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             add_i,
  input  logic             sub_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic [CNT_W-1:0] add_val_i,
  output logic [CNT_W-1:0] acc_o,
  output logic             le_den_o
);

  localparam logic [63:0] ACC_MAX = cnt_max(CNT_W);
  localparam logic [63:0] DEN_64  = 64'(DEN);

  logic [CNT_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (load_i) begin
      acc_d = load_val_i;
    end else if (add_i) begin
      acc_d = CNT_W'(sat_add(64'(acc_q), 64'(add_val_i), ACC_MAX));
    end else if (sub_i) begin
      acc_d = CNT_W'(sat_sub(64'(acc_q), DEN_64));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o    = acc_q;
  assign le_den_o = (64'(acc_q) <= DEN_64);

endmodule

`default_nettype wire

// File: rtl/apb_ratio_delayer.sv
// apb_ratio_delayer: stretches each APB transfer to ceil(n*NUM/DEN) upstream cycles (min n+1).
// Revision 1.0
`default_nettype none

module apb_ratio_delayer
  import apb_delayer_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_NUM = 466,
  parameter int WR_NUM = 466,
  parameter int DEN    = 100,
  parameter int CNT_W  = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  apb_ratio_delayer_if.slave  in_apb,
  apb_ratio_delayer_if.master out_apb
);

  localparam logic [63:0] ACC_MAX = cnt_max(CNT_W);
  localparam logic [63:0] DEN_64  = 64'(DEN);

  if (!params_legal(RD_NUM, WR_NUM, DEN, CNT_W)) begin : g_bad_params
    $error("apb_ratio_delayer: illegal RD_NUM/WR_NUM/DEN/CNT_W combination");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pslverr_q, pslverr_d;

  logic [63:0]       w_sel_num;
  logic              w_bypass, w_capture, w_hold_done, w_le_den;
  logic              w_acc_clr, w_acc_load, w_acc_add, w_acc_sub;
  logic [CNT_W-1:0]  w_load_val, w_inc_val, w_acc_unused;
  logic [ADDR_W-1:0] w_paddr;

  assign w_sel_num   = in_apb.pwrite ? 64'(WR_NUM) : 64'(RD_NUM);
  // A unity ratio never leaves IDLE, so the response path is a plain wire.
  assign w_bypass    = (state_q == ST_IDLE) && (w_sel_num == DEN_64);
  assign w_capture   = (state_q == ST_FWD) && in_apb.psel && in_apb.penable && out_apb.pready;
  assign w_hold_done = (state_q == ST_HOLD) && in_apb.psel && w_le_den;
  assign w_load_val  = CNT_W'(sat_add(64'd0, w_sel_num - DEN_64, ACC_MAX));
  assign w_inc_val   = CNT_W'(sat_sub(64'(num_q), DEN_64));

  delay_acc #(
    .CNT_W (CNT_W),
    .DEN   (DEN)
  ) u_acc (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear_i    (w_acc_clr),
    .load_i     (w_acc_load),
    .add_i      (w_acc_add),
    .sub_i      (w_acc_sub),
    .load_val_i (w_load_val),
    .add_val_i  (w_inc_val),
    .acc_o      (w_acc_unused),
    .le_den_o   (w_le_den)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      num_q     <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    prdata_d   = prdata_q;
    pslverr_d  = pslverr_q;
    w_acc_clr  = 1'b0;
    w_acc_load = 1'b0;
    w_acc_add  = 1'b0;
    w_acc_sub  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_apb.psel && !w_bypass) begin
          state_d    = ST_FWD;
          w_acc_load = 1'b1;
          num_d      = CNT_W'(sat_add(64'd0, w_sel_num, ACC_MAX));
        end
      end
      ST_FWD: begin
        if (!in_apb.psel) begin
          state_d   = ST_IDLE;
          w_acc_clr = 1'b1;
        end else begin
          // The capture cycle still counts as device time.
          w_acc_add = 1'b1;
          if (w_capture) begin
            state_d   = ST_HOLD;
            prdata_d  = out_apb.prdata;
            pslverr_d = out_apb.pslverr;
          end
        end
      end
      ST_HOLD: begin
        if (!in_apb.psel) begin
          state_d   = ST_IDLE;
          w_acc_clr = 1'b1;
        end else if (w_le_den) begin
          state_d = ST_IDLE;
        end else begin
          w_acc_sub = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w_paddr         = in_apb.paddr;
    out_apb.paddr   = w_paddr;
    out_apb.pprot   = in_apb.pprot;
    out_apb.pwrite  = in_apb.pwrite;
    out_apb.pwdata  = in_apb.pwdata;
    out_apb.pstrb   = in_apb.pstrb;
    out_apb.penable = in_apb.penable;
    out_apb.psel    = in_apb.psel && (state_q != ST_HOLD);
    if (w_bypass) begin
      in_apb.pready  = out_apb.pready;
      in_apb.prdata  = out_apb.prdata;
      in_apb.pslverr = out_apb.pslverr;
    end else begin
      in_apb.pready  = w_hold_done;
      in_apb.prdata  = w_hold_done ? prdata_q : '0;
      in_apb.pslverr = w_hold_done && pslverr_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_ratio_delayer.sv
// tb_apb_ratio_delayer: four differently-parametrised delayers driven by directed transfers.
// Revision 1.0
`default_nettype none

module tb_apb_ratio_delayer;

  localparam int RD_TAB  [4] = '{300, 466, 200, 255};
  localparam int WR_TAB  [4] = '{100, 150, 200, 255};
  localparam int DEN_TAB [4] = '{100, 100, 100, 1};
  localparam int CW_TAB  [4] = '{32, 32, 32, 8};
  localparam int LIMIT       = 600;

  typedef struct {
    int          d;
    int          cyc;
    int          n;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clock;
  logic        reset_n;
  logic [3:0]  psel_r, pen_r, pwr_r, dev_err;
  logic [31:0] paddr_r [4];
  logic [31:0] pwdata_r [4];
  logic [31:0] dev_data [4];
  int          dev_n [4];

  wire  [3:0]  rdy, err_w, opsel;
  wire  [31:0] rdata_w [4];
  wire  [31:0] oaddr [4];
  wire  [31:0] owdata [4];

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    apb_ratio_delayer_if #(.ADDR_W(32), .DATA_W(32)) u_up ();
    apb_ratio_delayer_if #(.ADDR_W(32), .DATA_W(32)) u_dn ();
    int wcnt;

    assign u_up.paddr   = paddr_r[g];
    assign u_up.psel    = psel_r[g];
    assign u_up.penable = pen_r[g];
    assign u_up.pprot   = 3'b010;
    assign u_up.pwrite  = pwr_r[g];
    assign u_up.pwdata  = pwdata_r[g];
    assign u_up.pstrb   = 4'hF;
    assign rdy[g]       = u_up.pready;
    assign err_w[g]     = u_up.pslverr;
    assign rdata_w[g]   = u_up.prdata;
    assign opsel[g]     = u_dn.psel;
    assign oaddr[g]     = u_dn.paddr;
    assign owdata[g]    = u_dn.pwdata;

    // Device: ready after n cycles from setup, data/err only on the ready cycle.
    assign u_dn.pready  = u_dn.psel & u_dn.penable & (wcnt == dev_n[g] - 2);
    assign u_dn.prdata  = u_dn.pready ? dev_data[g] : 32'd0;
    assign u_dn.pslverr = u_dn.pready & dev_err[g];

    always @(posedge clock or negedge reset_n) begin
      if (!reset_n) wcnt <= 0;
      else if (u_dn.psel && u_dn.penable && !u_dn.pready) wcnt <= wcnt + 1;
      else wcnt <= 0;
    end

    apb_ratio_delayer #(
      .ADDR_W (32),
      .DATA_W (32),
      .RD_NUM (RD_TAB[g]),
      .WR_NUM (WR_TAB[g]),
      .DEN    (DEN_TAB[g]),
      .CNT_W  (CW_TAB[g])
    ) u_dut (
      .clock   (clock),
      .reset_n (reset_n),
      .in_apb  (u_up),
      .out_apb (u_dn)
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cycles(input int num, input int den, input int n);
    int c;
    if (num == den) return n;
    c = (n * num + den - 1) / den;
    return (c > n + 1) ? c : n + 1;
  endfunction

  task automatic xfer(input int d, input bit wr, input int n, input logic [31:0] data,
                      input bit err, input int exp_cyc);
    exp_t        e;
    int          cyc, psel_cyc;
    bit          done, leak, pass_ok;
    logic [31:0] got_data;
    logic        got_err;
    sb.push_back('{d, exp_cyc, n, data, err});
    dev_n[d]    = n;
    dev_data[d] = data;
    dev_err[d]  = err;
    paddr_r[d]  = $urandom;
    pwdata_r[d] = $urandom;
    pwr_r[d]    = wr;
    psel_r[d]   = 1'b1;
    pen_r[d]    = 1'b0;
    cyc = 0; psel_cyc = 0; done = 0; leak = 0; pass_ok = 0; got_data = '0; got_err = 1'b0;
    while (!done && cyc < LIMIT) begin
      cyc++;
      @(negedge clock);
      if (cyc == 1) pass_ok = (oaddr[d] === paddr_r[d]) && (owdata[d] === pwdata_r[d]);
      if (opsel[d]) psel_cyc++;
      if (rdy[d]) begin
        done     = 1;
        got_data = rdata_w[d];
        got_err  = err_w[d];
      end else if (rdata_w[d] !== 32'd0 || err_w[d] !== 1'b0) begin
        leak = 1;
      end
      @(posedge clock); #1;
      if (!done) pen_r[d] = 1'b1;
    end
    e = sb.pop_front();
    check($sformatf("done[%0d]", e.d), 64'(done), 64'd1);
    check($sformatf("latency[%0d]", e.d), 64'(cyc), 64'(e.cyc));
    check($sformatf("prdata[%0d]", e.d), 64'(got_data), 64'(e.data));
    check($sformatf("pslverr[%0d]", e.d), 64'(got_err), 64'(e.err));
    check($sformatf("resp_leak[%0d]", e.d), 64'(leak), 64'd0);
    check($sformatf("dev_access[%0d]", e.d), 64'(psel_cyc), 64'(e.n));
    check($sformatf("passthru[%0d]", e.d), 64'(pass_ok), 64'd1);
  endtask

  task automatic drop(input int d);
    psel_r[d] = 1'b0;
    pen_r[d]  = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    bit seen;
    reset_n = 1'b0;
    psel_r = '0; pen_r = '0; pwr_r = '0; dev_err = '0;
    for (int i = 0; i < 4; i++) begin
      paddr_r[i] = '0; pwdata_r[i] = '0; dev_data[i] = '0; dev_n[i] = 2;
    end
    repeat (2) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_pready[%0d]", i), 64'(rdy[i]), 64'd0);
      check($sformatf("rst_prdata[%0d]", i), 64'(rdata_w[i]), 64'd0);
      check($sformatf("rst_pslverr[%0d]", i), 64'(err_w[i]), 64'd0);
    end
    psel_r[0] = 1'b1; #1;
    check("rst_psel_follow_hi", 64'(opsel[0]), 64'd1);
    psel_r[0] = 1'b0; #1;
    check("rst_psel_follow_lo", 64'(opsel[0]), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    xfer(0, 1'b0, 2, 32'hDEADBEEF, 1'b0, exp_cycles(RD_TAB[0], DEN_TAB[0], 2));
    drop(0);
    xfer(0, 1'b1, 3, 32'h00C0FFEE, 1'b0, exp_cycles(WR_TAB[0], DEN_TAB[0], 3));
    drop(0);

    // Read immediately followed by write, no idle cycle between them.
    xfer(1, 1'b0, 4, 32'hA5A55A5A, 1'b0, exp_cycles(RD_TAB[1], DEN_TAB[1], 4));
    xfer(1, 1'b1, 4, 32'h13572468, 1'b0, exp_cycles(WR_TAB[1], DEN_TAB[1], 4));
    drop(1);
    xfer(1, 1'b1, 2, 32'h0000FFFF, 1'b0, exp_cycles(WR_TAB[1], DEN_TAB[1], 2));
    drop(1);

    xfer(2, 1'b0, 2, 32'h12345678, 1'b1, exp_cycles(RD_TAB[2], DEN_TAB[2], 2));
    drop(2);

    // Reset pulse while DUT 2 is stretching in HOLD.
    dev_n[2] = 2; dev_data[2] = 32'hFEEDFACE; dev_err[2] = 1'b1;
    pwr_r[2] = 1'b0; psel_r[2] = 1'b1; pen_r[2] = 1'b0;
    @(posedge clock); #1;
    pen_r[2] = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    check("hold_psel_low", 64'(opsel[2]), 64'd0);
    check("hold_no_ready", 64'(rdy[2]), 64'd0);
    reset_n = 1'b0;
    psel_r[2] = 1'b0; pen_r[2] = 1'b0;
    #1;
    check("midrst_pready", 64'(rdy[2]), 64'd0);
    check("midrst_prdata", 64'(rdata_w[2]), 64'd0);
    check("midrst_pslverr", 64'(err_w[2]), 64'd0);
    seen = 0;
    repeat (3) begin
      @(negedge clock);
      if (rdy[2]) seen = 1;
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    if (rdy[2]) seen = 1;
    check("midrst_no_resp", 64'(seen), 64'd0);
    @(posedge clock); #1;
    xfer(2, 1'b0, 2, 32'h0BADF00D, 1'b0, exp_cycles(RD_TAB[2], DEN_TAB[2], 2));
    drop(2);

    // CNT_W=8, DEN=1: acc pins at 255 so HOLD lasts ceil(255/1) cycles after n=4.
    xfer(3, 1'b0, 4, 32'hCAFEF00D, 1'b0, 4 + 255);
    drop(3);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
